rv_sequencer: RTL and testbench

Parametrised multi-cycle sequencing controller for the RV32I core, successor to the single-FSM controller. It owns instruction sequencing only: fetch/memory handshakes with a bounded-wait timeout, an optional M-extension multiply/divide handshake, and precise trap entry for illegal instructions, ECALL/EBREAK, bus timeouts and an external interrupt. Datapath selects (ALU/shift/compare type, immediate type, operand muxes) remain in the combinational decoder; this block drives the write enables, memory controls and PC/writeback source selects.

---
 rtl/rv_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_rv_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_sequencer.sv
// rv_sequencer: multi-cycle RV32I sequencing controller with bus timeout,
// optional M-extension handshake and precise trap entry.
module rv_sequencer #(
    parameter bit ENABLE_M    = 1'b1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic        muldiv_done,
    input  logic        interrupt_pending,
    output logic        instruction_write_enable,
    output logic        pc_write_enable,
    output logic        register_file_write_enable,
    output logic        execute_result_write_enable,
    output logic        load_memory_data_write_enable,
    output logic        memory_enable,
    output logic        memory_command,
    output logic        muldiv_start,
    output logic [2:0]  wb_select,
    output logic [1:0]  pc_select,
    output logic        trap_enter,
    output logic [4:0]  trap_cause,
    output logic [2:0]  debug_state
);

    typedef enum logic [2:0] {
        FETCH       = 3'd0,
        DECODE      = 3'd1,
        EXECUTE     = 3'd2,
        MULDIV_WAIT = 3'd3,
        MEMORY      = 3'd4,
        WRITE_BACK  = 3'd5,
        TRAP        = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_CALCI  = 7'b0010011;
    localparam logic [6:0] OP_CALCR  = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // The accept cycle is the first cycle of the MEM_TIMEOUT window.
    localparam int CW    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LIMIT = (MEM_TIMEOUT > 1) ? MEM_TIMEOUT - 2 : 0;

    state_t          state, next_state;
    logic            outstanding;
    logic [CW-1:0]   count;
    logic [4:0]      cause_q, cause_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1;
    logic [11:0] imm12;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign imm12  = instruction[31:20];
    assign funct7 = instruction[31:25];

    logic is_load, is_store, is_m, is_csr, is_sys0;
    logic is_ecall, is_ebreak, is_mret;
    logic calci_ok, calcr_ok, illegal;
    logic do_m, jump, rf_write;
    logic [2:0] wb_sel;

    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_m      = opcode == OP_CALCR && funct7 == 7'b0000001;
    assign is_csr    = opcode == OP_SYSTEM && funct3 != 3'b000;
    assign is_sys0   = opcode == OP_SYSTEM && funct3 == 3'b000
                       && rs1 == 5'd0 && rd == 5'd0;
    assign is_ecall  = is_sys0 && imm12 == 12'h000;
    assign is_ebreak = is_sys0 && imm12 == 12'h001;
    assign is_mret   = is_sys0 && imm12 == 12'h302;
    assign do_m      = is_m && ENABLE_M;

    assign calci_ok = (funct3 == 3'b001) ? funct7 == 7'b0000000 :
                      (funct3 == 3'b101) ? (funct7 == 7'b0000000 ||
                                            funct7 == 7'b0100000) :
                      1'b1;
    assign calcr_ok = funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 &&
                       (funct3 == 3'b000 || funct3 == 3'b101));

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_FENCE: illegal = 1'b0;
            OP_CALCI:  illegal = !calci_ok;
            OP_CALCR:  illegal = is_m ? !ENABLE_M : !calcr_ok;
            OP_SYSTEM: illegal = funct3 == 3'b100;
            default:   illegal = 1'b1;
        endcase
    end

    assign jump = opcode == OP_JAL || opcode == OP_JALR || is_mret;
    assign rf_write = opcode == OP_LUI || opcode == OP_AUIPC ||
                      opcode == OP_JAL || opcode == OP_JALR ||
                      is_load || opcode == OP_CALCI ||
                      opcode == OP_CALCR || (is_csr && rd != 5'd0);
    assign wb_sel = (opcode == OP_LUI) ? 3'd1 :
                    (opcode == OP_JAL || opcode == OP_JALR) ? 3'd2 :
                    is_load ? 3'd3 :
                    is_csr  ? 3'd4 : 3'd0;

    logic fetch_req, mem_done, timeout;

    // An interrupt seen before the fetch request pre-empts it entirely.
    assign fetch_req = state == FETCH && !interrupt_pending;
    assign memory_enable = reset_n && memory_ready && !outstanding &&
                           (fetch_req || state == MEMORY);
    assign mem_done = memory_valid && (outstanding || memory_enable);
    assign timeout  = (MEM_TIMEOUT != 0) && outstanding && !memory_valid &&
                      count == CW'(LIMIT);
    assign memory_command = state == MEMORY && is_store;
    assign debug_state    = state;

    always_comb begin
        next_state                    = state;
        cause_d                       = cause_q;
        instruction_write_enable      = 1'b0;
        pc_write_enable               = 1'b0;
        register_file_write_enable    = 1'b0;
        execute_result_write_enable   = 1'b0;
        load_memory_data_write_enable = 1'b0;
        muldiv_start                  = 1'b0;
        wb_select                     = 3'd0;
        pc_select                     = 2'd0;
        trap_enter                    = 1'b0;
        trap_cause                    = 5'd0;
        unique case (state)
            FETCH: begin
                if (interrupt_pending && !outstanding) begin
                    next_state = TRAP;
                    cause_d    = 5'b1_1011;
                end else if (mem_done) begin
                    instruction_write_enable = 1'b1;
                    next_state               = DECODE;
                end else if (timeout) begin
                    next_state = TRAP;
                    cause_d    = 5'd1;
                end
            end
            DECODE: next_state = EXECUTE;
            EXECUTE: begin
                execute_result_write_enable = 1'b1;
                unique case (1'b1)
                    illegal: begin
                        next_state = TRAP;
                        cause_d    = 5'd2;
                    end
                    is_load, is_store: next_state = MEMORY;
                    do_m: begin
                        muldiv_start = 1'b1;
                        next_state   = MULDIV_WAIT;
                    end
                    is_ecall: begin
                        next_state = TRAP;
                        cause_d    = 5'd11;
                    end
                    is_ebreak: begin
                        next_state = TRAP;
                        cause_d    = 5'd3;
                    end
                    default: next_state = WRITE_BACK;
                endcase
            end
            MULDIV_WAIT: begin
                if (muldiv_done) begin
                    execute_result_write_enable = 1'b1;
                    next_state                  = WRITE_BACK;
                end
            end
            MEMORY: begin
                if (mem_done) begin
                    load_memory_data_write_enable = is_load;
                    next_state                    = WRITE_BACK;
                end else if (timeout) begin
                    next_state = TRAP;
                    cause_d    = is_load ? 5'd5 : 5'd7;
                end
            end
            WRITE_BACK: begin
                pc_write_enable            = 1'b1;
                register_file_write_enable = rf_write;
                wb_select                  = wb_sel;
                pc_select = jump ? 2'd1 :
                            (opcode == OP_BRANCH) ? 2'd2 : 2'd0;
                next_state = FETCH;
            end
            TRAP: begin
                trap_enter      = 1'b1;
                trap_cause      = cause_q;
                pc_select       = 2'd3;
                pc_write_enable = 1'b1;
                next_state      = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            outstanding <= 1'b0;
            count       <= '0;
            cause_q     <= 5'd0;
        end else begin
            state   <= next_state;
            cause_q <= cause_d;
            if (memory_enable && !memory_valid)
                outstanding <= 1'b1;
            else if (memory_valid || timeout)
                outstanding <= 1'b0;
            if (memory_enable)
                count <= '0;
            else if (outstanding)
                count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_sequencer.sv
// tb_rv_sequencer: directed checks of rv_sequencer sequencing, timeouts,
// traps and reset, using two parameterisations of the controller.
module tb_rv_sequencer;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_MUL   = 32'h0220_81B3;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;
    localparam logic [31:0] I_BEQ   = 32'h0000_0063;
    localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_a, rst_b, sel;
    logic [31:0] instruction;
    logic        memory_ready, memory_valid;
    logic        muldiv_done, interrupt_pending;
    wire  [21:0] va, vb;
    int          n_cmp, n_bad;
    int          starts, bad_wait;

    rv_sequencer #(.ENABLE_M(1'b1), .MEM_TIMEOUT(16)) dut_a (
        .clk(clk), .reset_n(rst_a), .instruction(instruction),
        .memory_ready(memory_ready), .memory_valid(memory_valid),
        .muldiv_done(muldiv_done), .interrupt_pending(interrupt_pending),
        .instruction_write_enable(va[21]), .pc_write_enable(va[20]),
        .register_file_write_enable(va[19]),
        .execute_result_write_enable(va[18]),
        .load_memory_data_write_enable(va[17]),
        .memory_enable(va[16]), .memory_command(va[15]),
        .muldiv_start(va[14]), .wb_select(va[13:11]),
        .pc_select(va[10:9]), .trap_enter(va[8]),
        .trap_cause(va[7:3]), .debug_state(va[2:0])
    );

    rv_sequencer #(.ENABLE_M(1'b0), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .reset_n(rst_b), .instruction(instruction),
        .memory_ready(memory_ready), .memory_valid(memory_valid),
        .muldiv_done(muldiv_done), .interrupt_pending(interrupt_pending),
        .instruction_write_enable(vb[21]), .pc_write_enable(vb[20]),
        .register_file_write_enable(vb[19]),
        .execute_result_write_enable(vb[18]),
        .load_memory_data_write_enable(vb[17]),
        .memory_enable(vb[16]), .memory_command(vb[15]),
        .muldiv_start(vb[14]), .wb_select(vb[13:11]),
        .pc_select(vb[10:9]), .trap_enter(vb[8]),
        .trap_cause(vb[7:3]), .debug_state(vb[2:0])
    );

    wire [21:0] v     = sel ? vb : va;
    wire        iwe   = v[21];
    wire        pcwe  = v[20];
    wire        rfwe  = v[19];
    wire        erwe  = v[18];
    wire        lmdwe = v[17];
    wire        me    = v[16];
    wire        mc    = v[15];
    wire        ms    = v[14];
    wire [2:0]  wb    = v[13:11];
    wire [1:0]  pcs   = v[10:9];
    wire        te    = v[8];
    wire [4:0]  tc    = v[7:3];
    wire [2:0]  ds    = v[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_to(input bit b);
        rst_a = 1'b0;
        rst_b = 1'b0;
        sel = b;
        memory_ready = 1'b1;
        memory_valid = 1'b1;
        interrupt_pending = 1'b1;
        muldiv_done = 1'b0;
        #1;
        chk("reset_outputs_zero", 32'(v), 32'd0);
        step();
        step();
        memory_ready = 1'b0;
        memory_valid = 1'b0;
        interrupt_pending = 1'b0;
        if (b) rst_b = 1'b1;
        else rst_a = 1'b1;
        #1;
    endtask

    // Reset, fetch with immediate valid, decode; returns settled in EXECUTE.
    task automatic start(input bit b, input logic [31:0] ins);
        reset_to(b);
        instruction = ins;
        memory_ready = 1'b1;
        memory_valid = 1'b1;
        #1;
        chk("fetch_state", 32'(ds), 32'd0);
        chk("fetch_iwe", 32'(iwe), 32'd1);
        step();
        memory_ready = 1'b0;
        memory_valid = 1'b0;
        #1;
        chk("decode_state", 32'(ds), 32'd1);
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        sel = 1'b0;
        instruction = 32'd0;
        memory_ready = 1'b0;
        memory_valid = 1'b0;
        muldiv_done = 1'b0;
        interrupt_pending = 1'b0;

        start(1'b0, I_ADDI);
        chk("addi_ex_state", 32'(ds), 32'd2);
        chk("addi_ex_erwe", 32'(erwe), 32'd1);
        step();
        chk("addi_wb_state", 32'(ds), 32'd5);
        chk("addi_wb_rfwe", 32'(rfwe), 32'd1);
        chk("addi_wb_pcwe", 32'(pcwe), 32'd1);
        chk("addi_wb_pcsel", 32'(pcs), 32'd0);
        step();
        chk("addi_back_fetch", 32'(ds), 32'd0);

        start(1'b0, I_LW);
        step();
        memory_ready = 1'b1;
        #1;
        chk("lw_mem_state", 32'(ds), 32'd4);
        chk("lw_mem_en", 32'(me), 32'd1);
        chk("lw_mem_cmd", 32'(mc), 32'd0);
        step();
        chk("lw_outstanding_no_en", 32'(me), 32'd0);
        chk("lw_wait_lmdwe", 32'(lmdwe), 32'd0);
        step();
        memory_ready = 1'b0;
        step();
        memory_valid = 1'b1;
        #1;
        chk("lw_valid_lmdwe", 32'(lmdwe), 32'd1);
        step();
        memory_valid = 1'b0;
        #1;
        chk("lw_wb_state", 32'(ds), 32'd5);
        chk("lw_wb_sel", 32'(wb), 32'd3);
        chk("lw_wb_lmdwe_once", 32'(lmdwe), 32'd0);
        chk("lw_no_trap", 32'(te), 32'd0);

        start(1'b1, I_SW);
        step();
        memory_ready = 1'b1;
        #1;
        chk("sw_mem_cmd", 32'(mc), 32'd1);
        chk("sw_mem_en", 32'(me), 32'd1);
        step();
        memory_ready = 1'b0;
        #1;
        step();
        step();
        chk("sw_still_memory", 32'(ds), 32'd4);
        step();
        chk("sw_timeout_state", 32'(ds), 32'd6);
        chk("sw_trap_enter", 32'(te), 32'd1);
        chk("sw_trap_cause", 32'(tc), 32'd7);
        chk("sw_trap_pcsel", 32'(pcs), 32'd3);
        chk("sw_trap_rfwe", 32'(rfwe), 32'd0);
        step();
        chk("sw_back_fetch", 32'(ds), 32'd0);

        start(1'b1, I_LW);
        step();
        memory_ready = 1'b1;
        #1;
        step();
        memory_ready = 1'b0;
        #1;
        step();
        step();
        memory_valid = 1'b1;
        #1;
        chk("lw_edge_lmdwe", 32'(lmdwe), 32'd1);
        step();
        memory_valid = 1'b0;
        #1;
        chk("lw_edge_no_trap", 32'(ds), 32'd5);

        start(1'b0, I_MUL);
        muldiv_done = 1'b1;
        #1;
        chk("mul_ex_start", 32'(ms), 32'd1);
        starts = int'(ms);
        step();
        muldiv_done = 1'b0;
        #1;
        chk("mul_wait_state", 32'(ds), 32'd3);
        starts += int'(ms);
        bad_wait = 0;
        for (int i = 2; i <= 32; i++) begin
            step();
            starts += int'(ms);
            if (ds !== 3'd3) bad_wait++;
        end
        chk("mul_held_in_wait", 32'(bad_wait), 32'd0);
        step();
        muldiv_done = 1'b1;
        #1;
        chk("mul_done_erwe", 32'(erwe), 32'd1);
        starts += int'(ms);
        step();
        muldiv_done = 1'b0;
        #1;
        chk("mul_wb_state", 32'(ds), 32'd5);
        chk("mul_wb_rfwe", 32'(rfwe), 32'd1);
        chk("mul_single_start", 32'(starts), 32'd1);

        start(1'b1, I_MUL);
        chk("mul_nom_no_start", 32'(ms), 32'd0);
        step();
        chk("mul_nom_trap", 32'(ds), 32'd6);
        chk("mul_nom_cause", 32'(tc), 32'd2);

        start(1'b0, I_BAD);
        step();
        chk("bad_op_cause", 32'(tc), 32'd2);

        start(1'b0, I_ECALL);
        step();
        chk("ecall_trap", 32'(te), 32'd1);
        chk("ecall_cause", 32'(tc), 32'd11);

        start(1'b0, I_BEQ);
        step();
        chk("beq_pcsel", 32'(pcs), 32'd2);
        chk("beq_no_rfwe", 32'(rfwe), 32'd0);

        reset_to(1'b0);
        interrupt_pending = 1'b1;
        memory_ready = 1'b1;
        #1;
        chk("irq_no_mem_en", 32'(me), 32'd0);
        step();
        interrupt_pending = 1'b0;
        memory_ready = 1'b0;
        #1;
        chk("irq_trap_state", 32'(ds), 32'd6);
        chk("irq_trap_cause", 32'(tc), 32'b1_1011);
        chk("irq_trap_pcsel", 32'(pcs), 32'd3);

        start(1'b0, I_LW);
        step();
        memory_ready = 1'b1;
        #1;
        step();
        chk("rst_mid_outstanding", 32'(ds), 32'd4);
        rst_a = 1'b0;
        #1;
        chk("rst_mid_all_zero", 32'(v), 32'd0);
        step();
        memory_ready = 1'b0;
        memory_valid = 1'b1;
        rst_a = 1'b1;
        #1;
        chk("stray_valid_no_iwe", 32'(iwe), 32'd0);
        step();
        memory_valid = 1'b0;
        #1;
        chk("stray_valid_stay_fetch", 32'(ds), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
